// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single unified memory.
// One access per two cycles at best; misaligned or unanswered accesses complete with err.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic        r_lastDma;
  logic        r_ownerDma;
  logic        r_misalign;
  logic [7:0]  r_cnt;

  logic        w_grantCpu;
  logic        w_grantDma;
  logic        w_selWe;
  logic [31:0] w_selAddr;
  logic [31:0] w_selWdata;

  // CPU wins a tie only when DMA owned the previous access.
  assign w_grantCpu = cpu_req & (~dma_req | r_lastDma);
  assign w_grantDma = dma_req & ~w_grantCpu;
  assign w_selWe    = w_grantDma ? dma_we    : cpu_we;
  assign w_selAddr  = w_grantDma ? dma_addr  : cpu_addr;
  assign w_selWdata = w_grantDma ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lastDma  <= 1'b1;
      r_ownerDma <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= 8'd0;
      cpu_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'd0;
      dma_gnt    <= 1'b0;
      dma_done   <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      cpu_err  <= 1'b0;
      dma_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantCpu || w_grantDma) begin
            r_state    <= ACCESS;
            r_ownerDma <= w_grantDma;
            r_lastDma  <= w_grantDma;
            cpu_gnt    <= w_grantCpu;
            dma_gnt    <= w_grantDma;
            mem_we     <= w_selWe;
            mem_addr   <= {w_selAddr[31:2], 2'b00};
            mem_wdata  <= w_selWdata;
            r_misalign <= |w_selAddr[1:0];
            mem_en     <= ~(|w_selAddr[1:0]);
            r_cnt      <= 8'd0;
          end
        end
        ACCESS: begin
          // Misaligned: no memory cycle was issued, so fail right after the grant.
          if (r_misalign || mem_ready || (r_cnt == LAST_CYCLE)) begin
            r_state  <= IDLE;
            mem_en   <= 1'b0;
            cpu_done <= ~r_ownerDma;
            dma_done <= r_ownerDma;
            cpu_err  <= ~r_ownerDma & (r_misalign | ~mem_ready);
            dma_err  <= r_ownerDma & (r_misalign | ~mem_ready);
            if (!r_misalign && mem_ready && !mem_we) begin
              if (r_ownerDma) dma_rdata <= mem_rdata;
              else            cpu_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_done, cpu_err, dma_gnt, dma_done, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int testCount;
  int failCount;
  int accessCycles;
  logic expDma;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
    dma_req = dReq; dma_we = dWe; dma_addr = dAddr; dma_wdata = dWdata;
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    checkOutput("rst_gnt", 32'({cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_err, dma_err}), 32'd0);
    checkOutput("rst_mem", 32'({mem_en, mem_we}), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_rdata", cpu_rdata | dma_rdata | mem_wdata, 32'd0);
    advanceCycle();
    advanceCycle();
    reset = 1'b0;

    // CPU aligned read, ready one cycle after mem_en
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    advanceCycle();
    checkOutput("rd_gnt", 32'({cpu_gnt, dma_gnt}), 32'd2);
    checkOutput("rd_mem_en_we", 32'({mem_en, mem_we}), 32'd2);
    checkOutput("rd_mem_addr", mem_addr, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    advanceCycle();
    checkOutput("rd_done_err", 32'({cpu_done, cpu_err, cpu_gnt, mem_en}), 32'd8);
    checkOutput("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    mem_ready = 1'b0;
    advanceCycle();
    checkOutput("rd_done_clear", 32'({cpu_done, cpu_err}), 32'd0);

    // Both requesting, memory always ready: last owner was CPU, so DMA goes first
    applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_00A5;
    for (int i = 0; i < 4; i++) begin
      advanceCycle();
      expDma = (i % 2 == 0);
      checkOutput("rr_gnt", 32'({cpu_gnt, dma_gnt}), expDma ? 32'd1 : 32'd2);
      checkOutput("rr_mem_addr", mem_addr, expDma ? 32'h200 : 32'h100);
      advanceCycle();
      checkOutput("rr_done", 32'({cpu_done, dma_done, cpu_err, dma_err}), expDma ? 32'd4 : 32'd8);
    end

    // DMA write with ready withheld for 5 cycles; CPU keeps requesting and must be ignored
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_0000;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    advanceCycle();
    checkOutput("wr_gnt", 32'({cpu_gnt, dma_gnt}), 32'd1);
    dma_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("wr_mem_en_we", 32'({mem_en, mem_we}), 32'd3);
      checkOutput("wr_mem_addr", mem_addr, 32'h20);
      checkOutput("wr_mem_wdata", mem_wdata, 32'h1234_5678);
      checkOutput("wr_cpu_quiet", 32'({cpu_gnt, cpu_done, dma_done}), 32'd0);
      if (k == 5) mem_ready = 1'b1;
      advanceCycle();
    end
    mem_ready = 1'b0;
    checkOutput("wr_done_err", 32'({dma_done, dma_err, mem_en}), 32'd4);
    checkOutput("wr_rdata_kept", dma_rdata, 32'h0000_00A5);

    // Held CPU request is granted next and then times out
    advanceCycle();
    checkOutput("to_gnt", 32'({cpu_gnt, dma_gnt}), 32'd2);
    cpu_req = 1'b0;
    accessCycles = 0;
    for (int k = 0; k < 40 && mem_en; k++) begin
      accessCycles++;
      advanceCycle();
    end
    checkOutput("to_cycles", 32'(accessCycles), 32'd16);
    checkOutput("to_done_err", 32'({cpu_done, cpu_err, mem_en}), 32'd6);
    checkOutput("to_rdata_kept", cpu_rdata, 32'h0000_00A5);
    advanceCycle();
    checkOutput("to_err_clear", 32'({cpu_done, cpu_err}), 32'd0);

    // Misaligned CPU read never touches memory
    applyStimulus(1'b1, 1'b0, 32'h13, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    advanceCycle();
    checkOutput("mis_gnt", 32'({cpu_gnt, mem_en}), 32'd2);
    cpu_req = 1'b0;
    advanceCycle();
    checkOutput("mis_done_err", 32'({cpu_done, cpu_err, mem_en}), 32'd6);

    // Reset in the third cycle of a DMA access
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0);
    advanceCycle();
    checkOutput("rst2_gnt", 32'({dma_gnt, mem_en}), 32'd3);
    dma_req = 1'b0;
    advanceCycle();
    advanceCycle();
    checkOutput("rst2_pre", 32'({mem_en, dma_done}), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("rst2_mem_en", 32'({mem_en, dma_done}), 32'd0);
    checkOutput("rst2_mem_addr", mem_addr, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h50, 32'd0, 1'b1, 1'b0, 32'h60, 32'd0);
    advanceCycle();
    checkOutput("rst2_hold", 32'({dma_done, cpu_gnt, dma_gnt, mem_en}), 32'd0);
    reset = 1'b0;
    advanceCycle();
    checkOutput("rst2_cpu_first", 32'({cpu_gnt, dma_gnt}), 32'd2);
    checkOutput("rst2_addr", mem_addr, 32'h50);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    advanceCycle();
    checkOutput("rst2_done", 32'({cpu_done, cpu_err, dma_done}), 32'd4);
    checkOutput("rst2_rdata", cpu_rdata, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles spent waiting for mem_ready before the access is aborted (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_req, cpu_we (input, 1 bit each): CPU request valid and write enable.
REQ-005 SHALL have ports cpu_addr, cpu_wdata (input, 32 bits each): CPU byte address and write data.
REQ-006 SHALL have ports cpu_gnt, cpu_done, cpu_err (output, 1 bit each) and cpu_rdata (output, 32 bits): CPU grant pulse, completion pulse, error flag and read data.
REQ-007 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_err, dma_rdata, with the same directions, widths and meanings as the cpu_* ports.
REQ-008 SHALL have ports mem_en, mem_we (output, 1 bit each) and mem_addr, mem_wdata (output, 32 bits each): request to the unified memory.
REQ-009 SHALL have ports mem_rdata (input, 32 bits) and mem_ready (input, 1 bit): memory read data and access-complete strobe.

Function
REQ-010 SHALL implement a state machine with states IDLE and ACCESS; all outputs are registered.
REQ-011 In IDLE with at least one req high at a rising edge, the arbiter SHALL select one owner, latch that owner's we/addr/wdata, pulse the owner's gnt for exactly one cycle, and enter ACCESS.
REQ-012 Arbitration SHALL be round-robin. On simultaneous requests the port not granted most recently wins; after reset the CPU is treated as next in line.
REQ-013 A single requester SHALL be granted on every IDLE cycle it requests, regardless of last-owner history.
REQ-014 In ACCESS, mem_en SHALL be 1, with mem_we, mem_addr and mem_wdata held stable at the latched values until the state leaves ACCESS.
REQ-015 mem_addr SHALL equal the latched address with bits [1:0] forced to 0.
REQ-016 On a rising edge in ACCESS with mem_ready=1, the arbiter SHALL load the owner's rdata from mem_rdata on reads (rdata unchanged on writes), pulse the owner's done for one cycle with err=0, and return to IDLE.
REQ-017 The owner's done/err/rdata update SHALL appear in the cycle after mem_ready is sampled, which is the same cycle the state is IDLE again.
REQ-018 A cycle counter SHALL count ACCESS cycles. If mem_ready has not been sampled high after TIMEOUT cycles, the arbiter SHALL pulse done with err=1, leave rdata unchanged, drop mem_en and return to IDLE.
REQ-019 If the latched address has addr[1:0]!=0, the arbiter SHALL skip the memory cycle entirely (mem_en stays 0) and pulse done with err=1 in the cycle after gnt.
REQ-020 err SHALL be valid only while done=1 and SHALL be 0 at all other times.
REQ-021 Requester inputs SHALL be ignored while in ACCESS. A requester need not drop req after gnt; a req still high in IDLE is treated as a new request.
REQ-022 The non-owner's gnt and done SHALL remain 0 throughout another port's access.
REQ-023 Minimum throughput SHALL be one access per two cycles: IDLE, then ACCESS with mem_ready=1.

Reset
REQ-024 While reset=1, the arbiter SHALL immediately force state=IDLE, all gnt/done/err/mem_en/mem_we = 0, mem_addr/mem_wdata/cpu_rdata/dma_rdata = 0, timeout counter = 0, and last owner = DMA (so the CPU is next).
REQ-025 A reset asserted during ACCESS SHALL abandon the access: no done pulse is issued and mem_en drops asynchronously.

Verification
REQ-026 CPU read, addr=0x00000010, mem_ready one cycle after mem_en with mem_rdata=0xDEADBEEF -> cpu_gnt pulses 1 cycle, mem_addr=0x10, mem_we=0, then cpu_done=1, cpu_err=0, cpu_rdata=0xDEADBEEF.
REQ-027 cpu_req and dma_req held high continuously, mem_ready tied 1 -> grants alternate CPU, DMA, CPU, DMA, with one access completing every 2 cycles.
REQ-028 DMA write, addr=0x20, wdata=0x12345678, mem_ready withheld for 5 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable for all 6 ACCESS cycles, then dma_done=1, dma_err=0, dma_rdata unchanged.
REQ-029 CPU read with mem_ready never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, then cpu_done=1, cpu_err=1, mem_en=0.
REQ-030 CPU read at addr=0x00000013 -> mem_en never asserts; cpu_done=1 and cpu_err=1 in the cycle after cpu_gnt.
REQ-031 reset asserted during the 3rd cycle of a DMA access -> mem_en=0 immediately, no dma_done; after release, simultaneous requests are granted to the CPU first.
